// File: rtl/rsa_stream_io.sv
`timescale 1ns/1ps
// Purpose: word-serial operand loader / result unloader wrapped around the rsa4k modexp core.
// Latency: last input word -> go is 2 cycles (CHECK, then RUN); done -> first out_valid is 1 cycle.
// Backpressure: in_ready low outside LOAD; out_data held stable while out_valid && !out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready   input stream: message, exponent, modulus, each LSW first
//   out_data/valid/ready  result stream, LSW first; out_last marks the final word
//   err                   one-cycle pulse when an even modulus rejects the job
//   busy                  high whenever the block is not accepting input (any state but LOAD)
//   message/exponent/modulus/go   operands and start to the core
//   done/cypher           completion and result from the core
module rsa_stream_io #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WORD-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] message,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] modulus,
    output logic             go,
    input  logic             done,
    input  logic [WIDTH-1:0] cypher
);

    localparam int NW = WIDTH / WORD;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);

    typedef enum logic [1:0] {LOAD, CHECK, RUN, UNLOAD} state_t;

    state_t state_q, state_d;

    // The 0..3*NW-1 input word count is kept as (operand select, word index)
    // so no divider is needed; the word index is reused for unloading.
    logic [CW-1:0] widx_q;
    logic [1:0]    opsel_q;

    logic [NW-1:0][WORD-1:0] msg_q, exp_q, mod_q, res_q;

    logic last_word;
    assign last_word = (widx_q == LAST_W);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_valid && last_word && (opsel_q == 2'd2)) state_d = CHECK;
            CHECK:   state_d = mod_q[0][0] ? RUN : LOAD;
            RUN:     if (done) state_d = UNLOAD;
            UNLOAD:  if (out_ready && last_word) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Operand assembly, result capture and word counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            widx_q  <= '0;
            opsel_q <= 2'd0;
            msg_q   <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        case (opsel_q)
                            2'd0:    msg_q[widx_q] <= in_data;
                            2'd1:    exp_q[widx_q] <= in_data;
                            default: mod_q[widx_q] <= in_data;
                        endcase
                        if (last_word) begin
                            widx_q  <= '0;
                            opsel_q <= (opsel_q == 2'd2) ? 2'd0 : opsel_q + 2'd1;
                        end else begin
                            widx_q  <= widx_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (done) res_q <= cypher;
                end
                UNLOAD: begin
                    if (out_ready) widx_q <= last_word ? '0 : widx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register so go falls with reset.
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign go        = (state_q == RUN);
    assign err       = (state_q == CHECK) && !mod_q[0][0];
    assign out_valid = (state_q == UNLOAD);
    assign out_last  = (state_q == UNLOAD) && last_word;
    assign out_data  = (state_q == UNLOAD) ? res_q[widx_q] : '0;

    assign message  = msg_q;
    assign exponent = exp_q;
    assign modulus  = mod_q;

endmodule

// File: tb/tb_rsa_stream_io.sv
`timescale 1ns/1ps
module tb_rsa_stream_io;

    localparam int WIDTH = 128;
    localparam int WORD  = 32;
    localparam int NW    = WIDTH / WORD;

    logic             clk = 1'b0;
    logic             reset;
    logic [WORD-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             err;
    logic             busy;
    logic [WIDTH-1:0] message, exponent, modulus;
    logic             go;
    logic             done;
    logic [WIDTH-1:0] cypher;

    logic             done_core = 1'b0;
    logic             done_force = 1'b0;
    int               core_cnt = 0;
    int               err_cnt = 0;
    int               go_cnt = 0;

    int checks = 0;
    int failures = 0;

    assign done = done_core | done_force;

    always #5 clk = ~clk;

    rsa_stream_io #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err(err), .busy(busy),
        .message(message), .exponent(exponent), .modulus(modulus),
        .go(go), .done(done), .cypher(cypher)
    );

    // Stand-in core: answers with the preset cypher 4 cycles after go rises.
    always @(posedge clk) begin
        if (go && !done_core) begin
            if (core_cnt == 3) begin
                done_core <= 1'b1;
                core_cnt  <= 0;
            end else begin
                core_cnt  <= core_cnt + 1;
            end
        end else begin
            done_core <= 1'b0;
            core_cnt  <= 0;
        end
    end

    always @(posedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (go)  go_cnt  <= go_cnt + 1;
    end

    // Streams message, exponent, modulus LSW first. With gaps, in_valid drops
    // every other word (garbage data on the bus) and one spurious done pulses.
    task automatic send_job(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                            input logic [WIDTH-1:0] n, input bit gaps, output bit ok);
        logic [3*WIDTH-1:0] all;
        all = {n, e, m};
        ok  = 1'b1;
        for (int j = 0; j < 3*NW; j++) begin
            if (gaps && (j % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = 32'hDEADBEEF;
                if (j == 5) done_force = 1'b1;
                @(negedge clk);
                done_force = 1'b0;
            end
            in_data  = all[j*WORD +: WORD];
            in_valid = 1'b1;
            for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
            if (!in_ready) ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Drains one result, optionally stalling out_ready 0..5 cycles per word.
    task automatic collect(input bit stall, output logic [WIDTH-1:0] got, output int nxfer,
                           output int lastbad, output int unstable);
        bit              fresh;
        int              stall_left;
        logic [WORD-1:0] held;
        got = '0; nxfer = 0; lastbad = 0; unstable = 0;
        fresh = 1'b1; stall_left = 0; held = '0;
        for (int c = 0; c < 300 && nxfer < NW; c++) begin
            if (out_valid && fresh) begin
                held       = out_data;
                fresh      = 1'b0;
                stall_left = stall ? $urandom_range(0, 5) : 0;
            end
            if (out_valid && out_data !== held) unstable++;
            out_ready = (stall_left == 0);
            if (out_valid && out_ready) begin
                got[nxfer*WORD +: WORD] = out_data;
                if (out_last !== (nxfer == NW-1)) lastbad++;
                nxfer++;
                fresh = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cypher = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({go, out_valid, out_last, err, busy} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got go/ov/ol/err/busy=%b exp=00000", {go, out_valid, out_last, err, busy}); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if ({message, exponent, modulus} !== '0) begin failures++; $display("FAIL reset_operands got nonzero exp=0"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    endtask

    task automatic test_basic_job;
        bit ok; int nx, lb, us, e0;
        logic [WIDTH-1:0] got;
        e0 = err_cnt;
        cypher = 128'h8;
        send_job(128'h32, 128'd37, 128'd77, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_in_accept got ok=%b exp=1", ok); end
        checks++; if (message !== 128'h32 || exponent !== 128'd37 || modulus !== 128'd77) begin failures++; $display("FAIL basic_operands got m=%h e=%h n=%h exp 32/25/4d", message, exponent, modulus); end
        checks++; if (go !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_check_state got go=%b in_ready=%b busy=%b exp 0/0/1", go, in_ready, busy); end
        @(negedge clk);
        checks++; if (go !== 1'b1) begin failures++; $display("FAIL basic_go_latency got go=%b exp=1", go); end
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_timeout got done=%b exp=1", done); end
        checks++; if (message !== 128'h32 || modulus !== 128'd77) begin failures++; $display("FAIL basic_run_stable got m=%h n=%h exp 32/4d", message, modulus); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || go !== 1'b0) begin failures++; $display("FAIL basic_done_to_valid got out_valid=%b go=%b exp 1/0", out_valid, go); end
        collect(1'b0, got, nx, lb, us);
        checks++; if (got !== 128'h8) begin failures++; $display("FAIL basic_result got=%h exp=8", got); end
        checks++; if (nx !== NW || lb !== 0) begin failures++; $display("FAIL basic_stream got xfers=%0d last_errs=%0d exp %0d/0", nx, lb, NW); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_return_load got ov=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL basic_no_err got err_cycles=%0d exp=%0d", err_cnt, e0); end
    endtask

    task automatic test_even_modulus;
        bit ok; int g0, e0;
        g0 = go_cnt; e0 = err_cnt;
        send_job(128'h32, 128'd37, 128'd76, 1'b0, ok);
        checks++; if (err !== 1'b1 || go !== 1'b0) begin failures++; $display("FAIL even_err_pulse got err=%b go=%b exp 1/0", err, go); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL even_return got err=%b in_ready=%b busy=%b exp 0/1/0", err, in_ready, busy); end
        repeat (3) @(negedge clk);
        checks++; if (go_cnt !== g0 || err_cnt !== e0 + 1) begin failures++; $display("FAIL even_counts got go_cycles=%0d err_cycles=%0d exp %0d/%0d", go_cnt - g0, err_cnt - e0, 0, 1); end
        checks++; if (modulus !== 128'd76) begin failures++; $display("FAIL even_mod_held got=%h exp=4c", modulus); end
    endtask

    task automatic test_backpressure;
        bit ok; int nx, lb, us, extra;
        logic [WIDTH-1:0] got;
        cypher = 128'h44444444_33333333_22222222_11111111;
        send_job(128'h5, 128'h3, 128'hF000000F_00000001, 1'b0, ok);
        collect(1'b1, got, nx, lb, us);
        checks++; if (got !== 128'h44444444_33333333_22222222_11111111) begin failures++; $display("FAIL bp_result got=%h exp=44444444333333332222222211111111", got); end
        checks++; if (nx !== NW || lb !== 0) begin failures++; $display("FAIL bp_xfers got xfers=%0d last_errs=%0d exp %0d/0", nx, lb, NW); end
        checks++; if (us !== 0) begin failures++; $display("FAIL bp_stable got unstable_cycles=%0d exp=0", us); end
        extra = 0;
        out_ready = 1'b1;
        repeat (3) begin if (out_valid) extra++; @(negedge clk); end
        out_ready = 1'b0;
        checks++; if (extra !== 0) begin failures++; $display("FAIL bp_extra_xfers got=%0d exp=0", extra); end
    endtask

    task automatic test_input_gaps;
        bit ok; int nx, lb, us;
        logic [WIDTH-1:0] got;
        cypher = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
        send_job(128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h00000000_00000000_00010001_00000003,
                 128'h80000000_00000000_00000000_000000A5, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL gaps_in_accept got ok=%b exp=1", ok); end
        checks++; if (message !== 128'h01234567_89ABCDEF_FEDCBA98_76543210) begin failures++; $display("FAIL gaps_message got=%h exp=0123456789abcdeffedcba9876543210", message); end
        checks++; if (exponent !== 128'h00000000_00000000_00010001_00000003 || modulus !== 128'h80000000_00000000_00000000_000000A5) begin failures++; $display("FAIL gaps_exp_mod got e=%h n=%h", exponent, modulus); end
        collect(1'b0, got, nx, lb, us);
        checks++; if (got !== 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0 || nx !== NW) begin failures++; $display("FAIL gaps_result got=%h xfers=%0d exp=cafef00d0badc0de123456789abcdef0/4", got, nx); end
    endtask

    task automatic test_reset_mid_run;
        bit ok; int nx, lb, us;
        logic [WIDTH-1:0] got;
        cypher = 128'hAAAA;
        send_job(128'h7, 128'h9, 128'h1F, 1'b0, ok);
        @(negedge clk);
        checks++; if (go !== 1'b1) begin failures++; $display("FAIL rst_pre_go got=%b exp=1", go); end
        #2 reset = 1'b0;
        #1;
        checks++; if (go !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_async got go=%b in_ready=%b busy=%b exp 0/1/0", go, in_ready, busy); end
        checks++; if ({message, exponent, modulus} !== '0) begin failures++; $display("FAIL rst_discard got operands nonzero exp=0"); end
        @(negedge clk);
        reset = 1'b1;
        cypher = 128'h00000004_00000003_00000002_00000001;
        send_job(128'h3, 128'h4, 128'h7, 1'b0, ok);
        checks++; if (message !== 128'h3 || exponent !== 128'h4 || modulus !== 128'h7) begin failures++; $display("FAIL rst_next_operands got m=%h e=%h n=%h exp 3/4/7", message, exponent, modulus); end
        collect(1'b0, got, nx, lb, us);
        checks++; if (got !== 128'h00000004_00000003_00000002_00000001 || nx !== NW || lb !== 0) begin failures++; $display("FAIL rst_next_result got=%h xfers=%0d exp=00000004000000030000000200000001/4", got, nx); end
    endtask

    task automatic test_back_to_back;
        bit ok; int nx, lb, us;
        logic [WIDTH-1:0] got;
        cypher = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
        send_job(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'hFFFF, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, ok);
        collect(1'b0, got, nx, lb, us);
        checks++; if (got !== 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC) begin failures++; $display("FAIL b2b_first got=%h exp=ffffffffeeeeeeeeddddddddcccccccc", got); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        cypher = 128'h4;
        send_job(128'h3, 128'h4, 128'h7, 1'b0, ok);
        checks++; if (message !== 128'h3 || exponent !== 128'h4 || modulus !== 128'h7) begin failures++; $display("FAIL b2b_operands got m=%h e=%h n=%h exp 3/4/7", message, exponent, modulus); end
        collect(1'b0, got, nx, lb, us);
        checks++; if (got !== 128'h4 || nx !== NW || lb !== 0) begin failures++; $display("FAIL b2b_second got=%h xfers=%0d exp=4/4", got, nx); end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_even_modulus();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
